// File: rtl/da_fir_pkg.sv
// Shared types and width helpers for the distributed-arithmetic FIR filter.
package da_fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_OUT
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int calc_ng(input int taps, input int group);
        return taps / group;
    endfunction

    function automatic int calc_acc_w(input int lut_w, input int data_w, input int taps,
                                      input int group);
        return lut_w + data_w + clog2(taps / group) + 1;
    endfunction

    function automatic int calc_caddr_w(input int taps, input int group);
        return clog2(taps / group) + group;
    endfunction

endpackage

// File: rtl/da_fir_lut_bank.sv
// One partial-sum LUT bank: 2^GROUP x LUT_W, bank-selected synchronous write,
// combinational read. Contents are deliberately not reset.
module da_fir_lut_bank #(
    parameter int GROUP   = 8,
    parameter int LUT_W   = 19,
    parameter int BANK_W  = 3,
    parameter int BANK_ID = 0
) (
    input  logic                    clk_fast,
    input  logic                    we,
    input  logic [BANK_W+GROUP-1:0] waddr,
    input  logic [LUT_W-1:0]        wdata,
    input  logic [GROUP-1:0]        raddr,
    output logic [LUT_W-1:0]        rdata
);

    logic [LUT_W-1:0] mem [2**GROUP];
    logic             bank_hit;

    generate
        if (BANK_W == 0) begin : g_single
            assign bank_hit = 1'b1;
        end else begin : g_multi
            assign bank_hit = (waddr[BANK_W+GROUP-1:GROUP] == BANK_W'(BANK_ID));
        end
    endgenerate

    always_ff @(posedge clk_fast) begin
        if (we && bank_hit) mem[waddr[GROUP-1:0]] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/da_fir_filter.sv
// Single-clock bit-serial distributed-arithmetic FIR filter with sample handshake.
// Define DA_FIR_SAT_EN to saturate dout instead of taking the plain bit slice.
module da_fir_filter
    import da_fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int TAPS      = 64,
    parameter int GROUP     = 8,
    parameter int LUT_W     = 19,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 15
) (
    input  logic                                 clk_fast,
    input  logic                                 resetn,
    input  logic [DATA_W-1:0]                    din,
    input  logic                                 valid_in,
    output logic                                 din_ready,
    input  logic [LUT_W-1:0]                     CIN,
    input  logic [calc_caddr_w(TAPS, GROUP)-1:0] CADDR,
    input  logic                                 CLOAD,
    output logic                                 coef_ready,
    output logic [OUT_W-1:0]                     dout,
    output logic                                 valid_out
);

    localparam int NG     = calc_ng(TAPS, GROUP);
    localparam int ACC_W  = calc_acc_w(LUT_W, DATA_W, TAPS, GROUP);
    localparam int BANK_W = clog2(NG);
    localparam int BIT_W  = (DATA_W > 1) ? clog2(DATA_W) : 1;

    state_t                    state, state_nx;
    logic [1:0]                rst_sync;
    logic [DATA_W-1:0]         xline [TAPS];
    logic signed [ACC_W-1:0]   acc, acc_nx, psum, pshift;
    logic [BIT_W-1:0]          bit_idx;
    logic                      accept, lut_we, last_bit;
    logic [GROUP-1:0]          bank_addr [NG];
    logic [LUT_W-1:0]          bank_data [NG];
    logic [OUT_W-1:0]          dout_nx;

    // Sample acceptance waits for the synchronised reset release.
    always_ff @(posedge clk_fast or negedge resetn) begin
        if (!resetn) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    always_comb begin
        state_nx   = state;
        din_ready  = 1'b0;
        coef_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                din_ready  = !CLOAD && rst_sync[1];
                coef_ready = 1'b1;
                state_nx   = (valid_in && din_ready) ? ST_CALC : ST_IDLE;
            end
            ST_CALC: begin
                if (last_bit) state_nx = ST_OUT;
            end
            ST_OUT: begin
                din_ready = !CLOAD && rst_sync[1];
                state_nx  = (valid_in && din_ready) ? ST_CALC : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign accept   = valid_in && din_ready;
    assign lut_we   = CLOAD && coef_ready;
    assign last_bit = (bit_idx == BIT_W'(DATA_W - 1));

    // Bank g sees bit-plane b of its GROUP taps as the LUT address.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            for (int j = 0; j < GROUP; j++) begin
                bank_addr[g][j] = xline[g*GROUP+j][bit_idx];
            end
        end
    end

    generate
        for (genvar g = 0; g < NG; g++) begin : g_bank
            da_fir_lut_bank #(
                .GROUP  (GROUP),
                .LUT_W  (LUT_W),
                .BANK_W (BANK_W),
                .BANK_ID(g)
            ) u_bank (
                .clk_fast(clk_fast),
                .we      (lut_we),
                .waddr   (CADDR),
                .wdata   (CIN),
                .raddr   (bank_addr[g]),
                .rdata   (bank_data[g])
            );
        end
    endgenerate

    always_comb begin
        psum = '0;
        for (int g = 0; g < NG; g++) begin
            psum = psum + ACC_W'($signed(bank_data[g]));
        end
    end

    // The sign bit-plane carries negative weight in two's complement.
    assign pshift = psum <<< bit_idx;
    assign acc_nx = last_bit ? (acc - pshift) : (acc + pshift);

`ifdef DA_FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [ACC_W-1:0] acc_scaled;
    assign acc_scaled = acc >>> OUT_SHIFT;

    always_comb begin
        if (acc_scaled > OUT_MAX)      dout_nx = {1'b0, {(OUT_W-1){1'b1}}};
        else if (acc_scaled < OUT_MIN) dout_nx = {1'b1, {(OUT_W-1){1'b0}}};
        else                           dout_nx = acc_scaled[OUT_W-1:0];
    end
`else
    assign dout_nx = acc[OUT_SHIFT +: OUT_W];
`endif

    always_ff @(posedge clk_fast or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            acc       <= '0;
            bit_idx   <= '0;
            dout      <= '0;
            valid_out <= 1'b0;
            for (int k = 0; k < TAPS; k++) xline[k] <= '0;
        end else begin
            state     <= state_nx;
            valid_out <= (state == ST_OUT);
            if (state == ST_OUT) dout <= dout_nx;
            if (accept) begin
                xline[0] <= din;
                for (int k = 1; k < TAPS; k++) xline[k] <= xline[k-1];
                acc     <= '0;
                bit_idx <= '0;
            end else if (state == ST_CALC) begin
                acc     <= acc_nx;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_da_fir_filter.sv
// Scoreboard bench for da_fir_filter: reference output is the direct-form sum of
// coefficient times sample, scaled and sliced (or saturated under DA_FIR_SAT_EN).
`timescale 1ns/1ps
module tb_da_fir_filter;

    localparam int DATA_W    = 16;
    localparam int TAPS      = 64;
    localparam int GROUP     = 8;
    localparam int LUT_W     = 19;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 15;
    localparam int NG        = TAPS / GROUP;
    localparam int CADDR_W   = 3 + GROUP;
    localparam int LAT       = DATA_W + 1;

    logic               clk_fast = 1'b0;
    logic               resetn   = 1'b0;
    logic [DATA_W-1:0]  din      = '0;
    logic               valid_in = 1'b0;
    logic               din_ready;
    logic [LUT_W-1:0]   CIN      = '0;
    logic [CADDR_W-1:0] CADDR    = '0;
    logic               CLOAD    = 1'b0;
    logic               coef_ready;
    logic [OUT_W-1:0]   dout;
    logic               valid_out;

    da_fir_filter #(
        .DATA_W(DATA_W), .TAPS(TAPS), .GROUP(GROUP),
        .LUT_W(LUT_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk_fast  (clk_fast),
        .resetn    (resetn),
        .din       (din),
        .valid_in  (valid_in),
        .din_ready (din_ready),
        .CIN       (CIN),
        .CADDR     (CADDR),
        .CLOAD     (CLOAD),
        .coef_ready(coef_ready),
        .dout      (dout),
        .valid_out (valid_out)
    );

    always #5 clk_fast = ~clk_fast;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;
    longint h  [TAPS];
    longint xm [TAPS];
    longint exp_q  [$];
    longint edge_q [$];
    longint stim_q [$];
    longint mon_e, mon_edge;

    always @(posedge clk_fast) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic longint expect_out(input longint y);
        longint s;
        s = y >>> OUT_SHIFT;
`ifdef DA_FIR_SAT_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s;
`else
        begin
            logic [OUT_W-1:0] t;
            t = s[OUT_W-1:0];
            return longint'($signed(t));
        end
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) xm[k] = 0;
        exp_q.delete();
        edge_q.delete();
    endtask

    task automatic model_accept(input longint d);
        longint y;
        y = 0;
        for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = d;
        for (int k = 0; k < TAPS; k++) y += h[k] * xm[k];
        exp_q.push_back(expect_out(y));
        edge_q.push_back(cyc + 1);
    endtask

    // Monitor: every valid_out pulse must match the oldest expected output.
    always @(posedge clk_fast) begin
        #1;
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", 1, 0);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_edge = edge_q.pop_front();
                check("dout", longint'($signed(dout)), mon_e);
                check("latency", cyc - mon_edge, LAT);
            end
        end
    end

    task automatic write_coef(input int bank, input int entry, input longint val);
        int guard;
        bit done;
        guard = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk_fast);
            CLOAD = 1'b1;
            CADDR = {bank[2:0], entry[7:0]};
            CIN   = val[LUT_W-1:0];
            #4;
            if (coef_ready) done = 1;
            else if (++guard > 4 * LAT) begin
                check("coef_write_timeout", 1, 0);
                done = 1;
            end
        end
    endtask

    task automatic load_lut();
        longint val;
        for (int g = 0; g < NG; g++) begin
            for (int e = 0; e < (1 << GROUP); e++) begin
                val = 0;
                for (int j = 0; j < GROUP; j++) if ((e >> j) & 1) val += h[g*GROUP+j];
                write_coef(g, e, val);
            end
        end
        @(negedge clk_fast) CLOAD = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 4 * LAT) begin
            @(negedge clk_fast);
            guard++;
        end
        if (exp_q.size() > 0) begin
            check("output_timeout", exp_q.size(), 0);
            exp_q.delete();
            edge_q.delete();
        end
    endtask

    // Sends stim_q back to back with valid_in held high throughout.
    task automatic run_stream();
        longint prev, tmp;
        int idle;
        prev = -1;
        idle = 0;
        while (stim_q.size() > 0) begin
            @(negedge clk_fast);
            tmp      = stim_q[0];
            din      = tmp[DATA_W-1:0];
            valid_in = 1'b1;
            #4;
            if (din_ready) begin
                if (prev >= 0) check("accept_period", cyc + 1 - prev, LAT);
                prev = cyc + 1;
                model_accept(stim_q.pop_front());
                idle = 0;
            end else if (++idle > 3 * LAT) begin
                check("accept_timeout", 1, 0);
                stim_q.delete();
            end
        end
        @(negedge clk_fast) valid_in = 1'b0;
        drain();
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_fast);
        resetn = 1'b1;
        repeat (4) @(negedge clk_fast);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint acc_edge;
        int guard;
        for (int k = 0; k < TAPS; k++) h[k] = 0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk_fast);
        check("rst_dout", dout, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_coef_ready", coef_ready, 1);
        resetn = 1'b1;
        repeat (4) @(negedge clk_fast);
        #4;
        check("idle_din_ready", din_ready, 1);
        check("idle_coef_ready", coef_ready, 1);

        // Impulse and MSB weight: h[0] = 2^15 gives dout = din after the >>15
        h[0] = 32768;
        load_lut();
        stim_q.push_back(100);
        stim_q.push_back(-5);
        stim_q.push_back(-32768);
        stim_q.push_back(32767);
        run_stream();

        // Load hold-off: write requested during CALC must wait for IDLE
        pulse_reset();
        @(negedge clk_fast);
        din = 16'd10;
        valid_in = 1'b1;
        #4;
        check("holdoff_first_accept", din_ready, 1);
        acc_edge = cyc + 1;
        model_accept(10);
        @(negedge clk_fast);
        din   = 16'd20;
        CLOAD = 1'b1;
        CADDR = {3'd0, 8'd1};
        CIN   = 19'd98304;
        #4;
        check("holdoff_coef_ready_calc", coef_ready, 0);
        check("holdoff_din_ready_calc", din_ready, 0);
        guard = 0;
        while (!coef_ready && guard < 3 * LAT) begin
            @(negedge clk_fast);
            #4;
            guard++;
        end
        check("holdoff_coef_ready_idle", coef_ready, 1);
        check("holdoff_din_refused", din_ready, 0);
        check("holdoff_write_cycle", cyc - acc_edge, LAT);
        @(negedge clk_fast);
        CLOAD    = 1'b0;
        valid_in = 1'b0;
        drain();

        // Held write has landed: bank 0 entry 1 now triples a lone newest sample
        pulse_reset();
        h[0] = 98304;
        stim_q.push_back(5);
        run_stream();
        write_coef(0, 1, 32768);
        @(negedge clk_fast) CLOAD = 1'b0;
        h[0] = 32768;

        // Reset mid-CALC aborts the computation
        @(negedge clk_fast);
        din = 16'd9;
        valid_in = 1'b1;
        #4;
        check("midcalc_accept", din_ready, 1);
        acc_edge = cyc + 1;
        model_accept(9);
        @(negedge clk_fast) valid_in = 1'b0;
        while (cyc < acc_edge + 8) begin
            @(posedge clk_fast);
            #1;
        end
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        check("midcalc_rst_dout", dout, 0);
        check("midcalc_rst_valid_out", valid_out, 0);
        repeat (2) @(negedge clk_fast);
        resetn = 1'b1;
        repeat (2 * LAT) @(negedge clk_fast);
        check("midcalc_dout_after", dout, 0);
        stim_q.push_back(7);
        run_stream();

        // Saturation versus wrap-around
        for (int k = 0; k < TAPS; k++) h[k] = 0;
        h[0] = 131072;
        load_lut();
        stim_q.push_back(12345);
        stim_q.push_back(-12345);
        stim_q.push_back(100);
        run_stream();

        // Random coefficients and samples at default scaling
        for (int k = 0; k < TAPS; k++) h[k] = longint'($urandom_range(0, 65535)) - 32768;
        load_lut();
        for (int i = 0; i < 2000; i++) stim_q.push_back(longint'($urandom_range(0, 65535)) - 32768);
        run_stream();

        repeat (4) @(negedge clk_fast);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
